barrel_pipe: RTL and testbench
==============================

# barrel_pipe

Pipelined, multi-mode barrel shifter with a valid/ready handshake, for datapaths where a single-cycle shift of wide words misses timing. It performs logical-right, arithmetic-right, logical-left and rotate-right shifts in log2(WIDTH) registered mux levels. It clamps out-of-range shift amounts, carries a sideband tag through the pipeline, and stalls the whole pipeline under output backpressure. It sits between an operand-issue stage and a writeback or accumulator stage.

## Interface
- WIDTH, 64: data word width; power of two, at least 4.
- SHIFT_WIDTH, 7: shift-amount port width; at least $clog2(WIDTH).
- SHIFT_MAX, 63: maximum non-rotate shift; 1 to WIDTH-1.
- TAG_WIDTH, 4: sideband tag width; at least 1.
- Local LEVELS = $clog2(WIDTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  input accepted this cycle when in_valid is also high.
- mode  in  2  shift mode: 00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
- shift  in  SHIFT_WIDTH  unsigned shift amount.
- in  in  WIDTH  operand.
- tag  in  TAG_WIDTH  sideband, passed through unchanged.
- ex  in  WIDTH  funnel extension word; present only with BARREL_PIPE_FUNNEL_EN.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output.
- out  out  WIDTH  result.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_ovf  out  1  shift amount was clamped.

## Operation
- Pre-stage (combinational, before level 0):
  - Modes 00/01/10: eff = min(shift, SHIFT_MAX); ovf = (shift > SHIFT_MAX).
  - Mode 11: eff = shift mod WIDTH; ovf = 0.
  - Fill bit: in[WIDTH-1] for mode 01, otherwise 0.
- Mux levels: level i (0..LEVELS-1) shifts its input by 2^i when eff[i] is 1, then registers the result.
  - Each level register carries: data, eff, mode, fill, tag, ovf and a valid bit.
- Result equations:
  - Mode 00: in >> eff, zero fill.
  - Mode 01: in >> eff, filled with in[WIDTH-1].
  - Mode 10: in << eff, zero fill.
  - Mode 11: rotate right by eff.
- Stall: advance = out_ready | ~out_valid.
  - in_ready = advance.
  - All level registers load only when advance is 1, so a stall freezes every level together.
  - Bubbles are not collapsed.
- A level loads valid = 0 when its upstream is invalid. Bubbles propagate; stale data is never marked valid.
- out, out_tag, out_ovf and out_valid are driven directly from the last level register.
- Results leave in the same order the inputs were accepted.

## Timing
- Latency: LEVELS cycles. A word accepted in cycle c is presented in cycle c+LEVELS when no stall occurs.
- Throughput: one word per cycle while out_ready stays high.
- A stall of N cycles delays every in-flight word by exactly N cycles.
- While out_valid=1 and out_ready=0, out, out_tag and out_ovf hold stable.
- Reset (asynchronous, effective immediately on rst_n low):
  - All level valid bits clear; out_valid=0.
  - out, out_tag, out_ovf and all internal data registers clear to 0.
  - in_ready is 1 once reset is released.
- Reset mid-operation: all in-flight words are discarded; no partial output is produced.
- The first accept after reset release produces its output in cycle c+LEVELS.
- Simultaneous events: an input accept and an output handoff in the same cycle is the normal streaming case. Occupancy stays constant.

## Configuration
- BARREL_PIPE_FUNNEL_EN defined:
  - The ex port exists.
  - Mode 00 result = low WIDTH bits of ({ex,in} >> eff).
  - Mode 10 result = high WIDTH bits of ({in,ex} << eff).
  - ex is carried through the levels alongside data.
  - Modes 01 and 11 are unaffected.
- BARREL_PIPE_FUNNEL_EN undefined:
  - The ex port is absent.
  - Modes 00 and 10 zero-fill.
  - No ex registers are implemented.

## Test plan
All scenarios use WIDTH=16, SHIFT_WIDTH=5, SHIFT_MAX=15, so LEVELS=4.
- Modes, no stall: feed 0x8F00/mode 00/shift 4, 0x8F00/01/4, 0x00F1/10/4, 0x1234/11/20 back-to-back.
  - Outputs 0x08F0, 0xF8F0, 0x0F10, 0x4123 in cycles c+4 through c+7.
  - out_ovf=0 on all four.
- Clamp: 0x8000/mode 00/shift 20 -> 0x0001, out_ovf=1. 0x8000/mode 01/shift 31 -> 0xFFFF, out_ovf=1. 0x8000/mode 11/shift 16 -> 0x8000, out_ovf=0.
- Backpressure: 8 inputs with tags 0..7 back-to-back; drop out_ready for 3 cycles mid-stream.
  - All 8 results appear, in tag order, values correct.
  - Outputs hold stable while stalled; in_ready=0 exactly in the stalled cycles.
- Bubbles: in_valid toggles every other cycle -> out_valid follows the same pattern delayed by 4 cycles; no duplicate results.
- Reset mid-flight: assert rst_n low with 3 words in flight.
  - out_valid=0 and out=0 immediately.
  - After release, none of the 3 words appears; a new word appears at c+4.
- Funnel (BARREL_PIPE_FUNNEL_EN defined): in=0x1234, ex=0xABCD.
  - Mode 00, shift 4 -> 0xD123.
  - Mode 10, shift 4 -> 0x234A.
  - Mode 01, shift 4 -> 0x0123.

Source files
------------

// File: rtl/barrel_pipe.sv
// Pipelined multi-mode barrel shifter: one registered mux level per shift bit, valid/ready stall.
// Optional funnel shifting for modes 00/10 is enabled by defining BARREL_PIPE_FUNNEL_EN.
module barrel_pipe #(
  parameter int WIDTH       = 64,
  parameter int SHIFT_WIDTH = 7,
  parameter int SHIFT_MAX   = 63,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             mode,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [WIDTH-1:0]       in,
  input  logic [TAG_WIDTH-1:0]   tag,
`ifdef BARREL_PIPE_FUNNEL_EN
  input  logic [WIDTH-1:0]       ex,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic                   out_ovf
);

  localparam int LEVELS = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_SRL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_SLL = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef struct packed {
    logic                 valid;
    logic [WIDTH-1:0]     data;
`ifdef BARREL_PIPE_FUNNEL_EN
    logic [WIDTH-1:0]     ex;
`endif
    logic [LEVELS-1:0]    eff;
    mode_e                mode;
    logic                 fill;
    logic [TAG_WIDTH-1:0] tag;
    logic                 ovf;
  } stage_t;

  stage_t pre;
  stage_t stage_in  [LEVELS];
  stage_t stage_nxt [LEVELS];
  stage_t stage_q   [LEVELS];
  logic   advance;

  assign advance  = out_ready | ~stage_q[LEVELS-1].valid;
  assign in_ready = advance;

  // Rotate wraps the amount; the other modes saturate at SHIFT_MAX and flag it.
  always_comb begin
    pre       = '0;
    pre.valid = in_valid;
    pre.data  = in;
`ifdef BARREL_PIPE_FUNNEL_EN
    pre.ex    = ex;
`endif
    pre.mode  = mode_e'(mode);
    pre.tag   = tag;
    pre.fill  = (mode == MODE_SRA) & in[WIDTH-1];
    if (mode == MODE_ROR) begin
      pre.eff = shift[LEVELS-1:0];
      pre.ovf = 1'b0;
    end else if (shift > SHIFT_WIDTH'(SHIFT_MAX)) begin
      pre.eff = LEVELS'(SHIFT_MAX);
      pre.ovf = 1'b1;
    end else begin
      pre.eff = shift[LEVELS-1:0];
      pre.ovf = 1'b0;
    end
  end

  always_comb begin
    stage_in[0] = pre;
    for (int i = 1; i < LEVELS; i++) begin
      stage_in[i] = stage_q[i-1];
    end
  end

  // Level i conditionally shifts by 2**i; the funnel word shifts alongside to feed the vacated bits.
  always_comb begin
    for (int i = 0; i < LEVELS; i++) begin
      stage_nxt[i] = stage_in[i];
      if (stage_in[i].eff[i]) begin
        case (stage_in[i].mode)
          MODE_SRL: begin
`ifdef BARREL_PIPE_FUNNEL_EN
            stage_nxt[i].data = (stage_in[i].data >> (1 << i)) | (stage_in[i].ex << (WIDTH - (1 << i)));
            stage_nxt[i].ex   = stage_in[i].ex >> (1 << i);
`else
            stage_nxt[i].data = stage_in[i].data >> (1 << i);
`endif
          end
          MODE_SRA: begin
            stage_nxt[i].data = (stage_in[i].data >> (1 << i)) |
                                ({WIDTH{stage_in[i].fill}} & ~({WIDTH{1'b1}} >> (1 << i)));
          end
          MODE_SLL: begin
`ifdef BARREL_PIPE_FUNNEL_EN
            stage_nxt[i].data = (stage_in[i].data << (1 << i)) | (stage_in[i].ex >> (WIDTH - (1 << i)));
            stage_nxt[i].ex   = stage_in[i].ex << (1 << i);
`else
            stage_nxt[i].data = stage_in[i].data << (1 << i);
`endif
          end
          MODE_ROR: begin
            stage_nxt[i].data = (stage_in[i].data >> (1 << i)) | (stage_in[i].data << (WIDTH - (1 << i)));
          end
        endcase
      end
    end
  end

  // Every level shares one enable so a stall freezes the pipe as a unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEVELS; i++) begin
        stage_q[i] <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < LEVELS; i++) begin
        stage_q[i] <= stage_nxt[i];
      end
    end
  end

  assign out_valid = stage_q[LEVELS-1].valid;
  assign out       = stage_q[LEVELS-1].data;
  assign out_tag   = stage_q[LEVELS-1].tag;
  assign out_ovf   = stage_q[LEVELS-1].ovf;

endmodule

// File: tb/tb_barrel_pipe.sv
// Scoreboard bench for barrel_pipe (WIDTH=16): directed cases, backpressure, bubbles, reset, random.
// Funnel cases are compiled in when BARREL_PIPE_FUNNEL_EN is defined.
module tb_barrel_pipe;

  localparam int WIDTH       = 16;
  localparam int SHIFT_WIDTH = 5;
  localparam int SHIFT_MAX   = 15;
  localparam int TAG_WIDTH   = 4;
  localparam int LEVELS      = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             mode;
  logic [SHIFT_WIDTH-1:0] shift;
  logic [WIDTH-1:0]       in_data;
  logic [TAG_WIDTH-1:0]   tag;
  logic [WIDTH-1:0]       ex_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [TAG_WIDTH-1:0]   out_tag;
  logic                   out_ovf;

  barrel_pipe #(
    .WIDTH(WIDTH), .SHIFT_WIDTH(SHIFT_WIDTH), .SHIFT_MAX(SHIFT_MAX), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .shift(shift),
    .in(in_data),
    .tag(tag),
`ifdef BARREL_PIPE_FUNNEL_EN
    .ex(ex_data),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out(out_data),
    .out_tag(out_tag),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0]     data;
    logic [TAG_WIDTH-1:0] tag;
    logic                 ovf;
    int                   acc_cyc;
    int                   acc_stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model from the shift rules, using wide concatenations and native operators.
  function automatic logic [WIDTH:0] model(input logic [1:0] m, input logic [SHIFT_WIDTH-1:0] s,
                                           input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e);
    int                      eff;
    logic [2*WIDTH-1:0]      w;
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0]        r;
    logic                    ovf;
    ovf = 1'b0;
    if (m == 2'b11) begin
      eff = int'(s) % WIDTH;
    end else begin
      ovf = (int'(s) > SHIFT_MAX);
      eff = ovf ? SHIFT_MAX : int'(s);
    end
    case (m)
      2'b00: begin w = {e, d} >> eff; r = w[WIDTH-1:0]; end
      2'b01: begin sd = d; r = sd >>> eff; end
      2'b10: begin w = {d, e} << eff; r = w[2*WIDTH-1:WIDTH]; end
      default: begin w = {d, d} >> eff; r = w[WIDTH-1:0]; end
    endcase
    return {ovf, r};
  endfunction

  // One clock of stimulus; accepted words push their expected result.
  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [SHIFT_WIDTH-1:0] s,
                               input logic [WIDTH-1:0] d, input logic [TAG_WIDTH-1:0] t,
                               input logic [WIDTH-1:0] e, input logic r,
                               input logic [WIDTH-1:0] exp_d, input logic exp_o, output logic accepted);
    @(posedge clk);
    #1;
    in_valid  = v;
    mode      = m;
    shift     = s;
    in_data   = d;
    tag       = t;
    ex_data   = e;
    out_ready = r;
    @(negedge clk);
    accepted = v && in_ready;
    if (accepted) exp_q.push_back('{data: exp_d, tag: t, ovf: exp_o, acc_cyc: cyc, acc_stall: stalls});
  endtask

  task automatic offer(input logic [1:0] m, input logic [SHIFT_WIDTH-1:0] s, input logic [WIDTH-1:0] d,
                       input logic [TAG_WIDTH-1:0] t, input logic [WIDTH-1:0] e,
                       input logic [WIDTH-1:0] exp_d, input logic exp_o);
    logic acc;
    applyStimulus(1'b1, m, s, d, t, e, 1'b1, exp_d, exp_o, acc);
    checkOutput("accept", acc, 1);
  endtask

  task automatic drain(input int budget);
    logic acc;
    int   n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1, '0, 1'b0, acc);
      #1;
      n++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
    repeat (4) applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1, '0, 1'b0, acc);
  endtask

  // Monitor: checks the head of the scoreboard on first presentation, stability while stalled.
  logic                 holding = 1'b0;
  logic [WIDTH-1:0]     held_data;
  logic [TAG_WIDTH-1:0] held_tag;
  logic                 held_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (out_valid) begin
        if (!holding) begin
          if (exp_q.size() == 0) begin
            checkOutput("spurious_output", 1, 0);
          end else begin
            checkOutput("latency", (cyc - exp_q[0].acc_cyc) - (stalls - exp_q[0].acc_stall), LEVELS);
            checkOutput("out", out_data, exp_q[0].data);
            checkOutput("out_tag", out_tag, exp_q[0].tag);
            checkOutput("out_ovf", out_ovf, exp_q[0].ovf);
          end
        end else begin
          checkOutput("hold_out", out_data, held_data);
          checkOutput("hold_tag", out_tag, held_tag);
          checkOutput("hold_ovf", out_ovf, held_ovf);
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        holding   = !out_ready;
        held_data = out_data;
        held_tag  = out_tag;
        held_ovf  = out_ovf;
      end else begin
        holding = 1'b0;
      end
      checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && !out_ready) stalls++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic             acc;
    int               idx;
    logic [WIDTH:0]   m_res;
    logic [1:0]       rm;
    logic [SHIFT_WIDTH-1:0] rs;
    logic [WIDTH-1:0] rd, re;
    logic             rv, rr;

    rst_n = 1'b1; in_valid = 1'b0; mode = '0; shift = '0; in_data = '0; tag = '0;
    ex_data = '0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out", out_data, 0);
    checkOutput("reset_out_tag", out_tag, 0);
    checkOutput("reset_out_ovf", out_ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("in_ready_after_reset", in_ready, 1);

    $display("[TB] modes, back-to-back");
    offer(2'b00, 5'd4,  16'h8F00, 4'd1, 16'h0000, 16'h08F0, 1'b0);
    offer(2'b01, 5'd4,  16'h8F00, 4'd2, 16'h0000, 16'hF8F0, 1'b0);
    offer(2'b10, 5'd4,  16'h00F1, 4'd3, 16'h0000, 16'h0F10, 1'b0);
    offer(2'b11, 5'd20, 16'h1234, 4'd4, 16'h0000, 16'h4123, 1'b0);

    $display("[TB] clamp and boundaries");
    offer(2'b00, 5'd20, 16'h8000, 4'd5, 16'h0000, 16'h0001, 1'b1);
    offer(2'b01, 5'd31, 16'h8000, 4'd6, 16'h0000, 16'hFFFF, 1'b1);
    offer(2'b11, 5'd16, 16'h8000, 4'd7, 16'h0000, 16'h8000, 1'b0);
    offer(2'b10, 5'd15, 16'h0001, 4'd8, 16'h0000, 16'h8000, 1'b0);
    offer(2'b00, 5'd16, 16'hFFFF, 4'd9, 16'h0000, 16'h0001, 1'b1);
    offer(2'b01, 5'd0,  16'hC3A5, 4'd10, 16'h0000, 16'hC3A5, 1'b0);
    drain(40);

`ifdef BARREL_PIPE_FUNNEL_EN
    $display("[TB] funnel");
    offer(2'b00, 5'd4, 16'h1234, 4'd11, 16'hABCD, 16'hD123, 1'b0);
    offer(2'b10, 5'd4, 16'h1234, 4'd12, 16'hABCD, 16'h234A, 1'b0);
    offer(2'b01, 5'd4, 16'h1234, 4'd13, 16'hABCD, 16'h0123, 1'b0);
    drain(40);
`endif

    $display("[TB] backpressure");
    idx = 0;
    for (int c = 0; c < 30 && idx < 8; c++) begin
      rd    = 16'hA5C3 ^ WIDTH'(idx * 16'h1111);
      m_res = model(2'(idx), SHIFT_WIDTH'(idx + 1), rd, 16'h0000);
      applyStimulus(1'b1, 2'(idx), SHIFT_WIDTH'(idx + 1), rd, TAG_WIDTH'(idx), 16'h0000,
                    !(c >= 5 && c <= 7), m_res[WIDTH-1:0], m_res[WIDTH], acc);
      if (acc) idx++;
    end
    checkOutput("bp_all_accepted", idx, 8);
    drain(40);

    $display("[TB] bubbles");
    for (int i = 0; i < 10; i++) begin
      rd    = 16'h0F0F + WIDTH'(i);
      m_res = model(2'b11, SHIFT_WIDTH'(i), rd, 16'h0000);
      applyStimulus(i % 2 == 0, 2'b11, SHIFT_WIDTH'(i), rd, TAG_WIDTH'(i), 16'h0000, 1'b1,
                    m_res[WIDTH-1:0], m_res[WIDTH], acc);
    end
    drain(40);

    $display("[TB] reset mid-flight");
    offer(2'b00, 5'd1, 16'h1111, 4'd1, 16'h0000, 16'h0888, 1'b0);
    offer(2'b00, 5'd2, 16'h2222, 4'd2, 16'h0000, 16'h0888, 1'b0);
    offer(2'b00, 5'd3, 16'h3333, 4'd3, 16'h0000, 16'h0666, 1'b0);
    offer(2'b00, 5'd4, 16'h4444, 4'd4, 16'h0000, 16'h0444, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_out", out_data, 0);
    checkOutput("midreset_out_tag", out_tag, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("in_ready_after_midreset", in_ready, 1);
    offer(2'b10, 5'd8, 16'h00AB, 4'd14, 16'h0000, 16'hAB00, 1'b0);
    drain(40);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 9) < 7);
      rr = ($urandom_range(0, 3) != 0);
      rm = 2'($urandom);
      rs = SHIFT_WIDTH'($urandom);
      rd = WIDTH'($urandom);
`ifdef BARREL_PIPE_FUNNEL_EN
      re = WIDTH'($urandom);
`else
      re = '0;
`endif
      m_res = model(rm, rs, rd, re);
      applyStimulus(rv, rm, rs, rd, TAG_WIDTH'($urandom), re, rr, m_res[WIDTH-1:0], m_res[WIDTH], acc);
    end
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
